// File: rtl/guess_pkg.sv
// ============================================================================
// Module  : guess_pkg
// Brief   : Shared state encoding and sizing helpers for the LED guessing game.
// Revision: 1.0
// ============================================================================
`default_nettype none

package guess_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        SHOW = 2'd2
    } state_t;

    // Index width for an n-entry bar; a single LED still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_sync.sv
// ============================================================================
// Module  : btn_sync
// Brief   : Two-flop synchronizer plus registered rising-edge detect.
// Revision: 1.0
// ============================================================================
`default_nettype none

module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic sync1;
    logic sync2;
    logic sync3;

    // press is registered so the FSM never sees a path straight from the pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            sync3 <= sync2;
            press <= sync2 & ~sync3;
        end
    end

endmodule

`default_nettype wire

// File: rtl/guess_game.sv
// ============================================================================
// Module  : guess_game
// Brief   : Rotating-LED guessing game: FSM, position, hold timer, score.
// Revision: 1.0
// ============================================================================
`default_nettype none

module guess_game
    import guess_pkg::*;
#(
    parameter int N_LEDS     = 8,
    parameter int HOLD_TICKS = 4,
    parameter int SCORE_W    = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         TICK,
    input  logic                         BTN,
    input  logic [idx_w(N_LEDS)-1:0]     TARGET,
    output logic [N_LEDS-1:0]            LED,
    output logic                         HIT,
    output logic                         MISS,
    output logic [SCORE_W-1:0]           SCORE,
    output logic [STATE_W-1:0]           STATE
);

    localparam int IDX_W  = idx_w(N_LEDS);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [IDX_W-1:0]  POS_LAST  = IDX_W'(N_LEDS - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [N_LEDS-1:0] LED_ONE   = N_LEDS'(1);

    logic                 press;

    state_t               state,  state_n;
    logic [IDX_W-1:0]     pos,    pos_n;
    logic [HOLD_W-1:0]    hold,   hold_n;
    logic                 hit,    hit_n;
    logic                 miss,   miss_n;
    logic [SCORE_W-1:0]   score,  score_n;
    logic [N_LEDS-1:0]    led,    led_n;

    btn_sync u_btn_sync (
        .clk   (CLK),
        .rst   (RST),
        .btn   (BTN),
        .press (press)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            pos   <= '0;
            hold  <= '0;
            hit   <= 1'b0;
            miss  <= 1'b0;
            score <= '0;
            led   <= '0;
        end else begin
            state <= state_n;
            pos   <= pos_n;
            hold  <= hold_n;
            hit   <= hit_n;
            miss  <= miss_n;
            score <= score_n;
            led   <= led_n;
        end
    end

    always_comb begin
        state_n = state;
        pos_n   = pos;
        hold_n  = hold;
        hit_n   = hit;
        miss_n  = miss;
        score_n = score;

        case (state)
            SPIN: begin
                // A press takes priority over a coincident tick and uses the
                // position currently on display. pos never exceeds N_LEDS-1,
                // so an out-of-range TARGET can never compare equal.
                if (press) begin
                    if (pos == TARGET) begin
                        hit_n = 1'b1;
                        if (score != '1) begin
                            score_n = score + 1'b1;
                        end
                    end else begin
                        miss_n = 1'b1;
                    end
                    hold_n  = HOLD_INIT;
                    state_n = SHOW;
                end else if (TICK) begin
                    pos_n = (pos == POS_LAST) ? '0 : pos + 1'b1;
                end
            end

            SHOW: begin
                if (TICK) begin
                    hold_n = hold - 1'b1;
                    if (hold == HOLD_ONE) begin
                        state_n = SPIN;
                        hit_n   = 1'b0;
                        miss_n  = 1'b0;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                hit_n   = 1'b0;
                miss_n  = 1'b0;
                if (press) begin
                    state_n = SPIN;
                    pos_n   = '0;
                end
            end
        endcase
    end

    // LED image is computed from next-state values so it is registered too.
    always_comb begin
        led_n = '0;
        case (state_n)
            SPIN:    led_n = LED_ONE << pos_n;
            SHOW:    led_n = hit_n ? '1 : (LED_ONE << pos_n);
            default: led_n = '0;
        endcase
    end

    assign LED   = led;
    assign HIT   = hit;
    assign MISS  = miss;
    assign SCORE = score;
    assign STATE = state;

endmodule

`default_nettype wire

// File: tb/tb_guess_game.sv
// ============================================================================
// Module  : tb_guess_game
// Brief   : Self-checking bench for guess_game with a cycle reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_guess_game;

    localparam int N    = 8;
    localparam int HOLD = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       TICK;
    logic       BTN;
    logic [2:0] TARGET;
    logic [7:0] LED,  LED2;
    logic       HIT,  HIT2;
    logic       MISS, MISS2;
    logic [7:0] SCORE;
    logic [1:0] SCORE2;
    logic [1:0] STATE, STATE2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: game rules in plain integers.
    int         m_state, m_pos, m_hold, m_score, m_score2;
    bit         m_hit, m_miss;
    logic [3:0] m_hist;

    always #5 CLK = ~CLK;

    guess_game #(.N_LEDS(N), .HOLD_TICKS(HOLD), .SCORE_W(8)) dut (
        .CLK(CLK), .RST(RST), .TICK(TICK), .BTN(BTN), .TARGET(TARGET),
        .LED(LED), .HIT(HIT), .MISS(MISS), .SCORE(SCORE), .STATE(STATE)
    );

    guess_game #(.N_LEDS(N), .HOLD_TICKS(HOLD), .SCORE_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .TICK(TICK), .BTN(BTN), .TARGET(TARGET),
        .LED(LED2), .HIT(HIT2), .MISS(MISS2), .SCORE(SCORE2), .STATE(STATE2)
    );

    // A button level first seen at edge e acts at edge e+3.
    always @(posedge CLK) begin
        if (RST) begin
            m_state <= 0; m_pos <= 0; m_hold <= 0; m_score <= 0; m_score2 <= 0;
            m_hit <= 0; m_miss <= 0; m_hist <= '0;
        end else begin
            m_hist <= {m_hist[2:0], BTN};
            case (m_state)
                0: if (m_hist[2] && !m_hist[3]) begin m_state <= 1; m_pos <= 0; end
                1: begin
                    if (m_hist[2] && !m_hist[3]) begin
                        if (m_pos == int'(TARGET)) begin
                            m_hit <= 1;
                            if (m_score < 255) m_score <= m_score + 1;
                            if (m_score2 < 3) m_score2 <= m_score2 + 1;
                        end else begin
                            m_miss <= 1;
                        end
                        m_hold  <= HOLD;
                        m_state <= 2;
                    end else if (TICK) begin
                        m_pos <= (m_pos + 1) % N;
                    end
                end
                default: if (TICK) begin
                    if (m_hold == 1) begin
                        m_state <= 1; m_hit <= 0; m_miss <= 0; m_hold <= 0;
                    end else begin
                        m_hold <= m_hold - 1;
                    end
                end
            endcase
        end
    end

    function automatic logic [7:0] exp_led();
        if (m_state == 1 || (m_state == 2 && !m_hit)) return 8'(1 << m_pos);
        if (m_state == 2) return 8'hFF;
        return 8'h00;
    endfunction

    task automatic step(input logic t, input logic b);
        TICK = t;
        BTN  = b;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step(0, 0);
        step(0, 0);
        RST = 1'b0;
    endtask

    // Steer to SPIN, then press with TICK quiet so the guess lands on m_pos.
    task automatic do_guess(input bit want_hit);
        for (int g = 0; g < 20 && m_state == 2; g++) begin
            step(1, 0);
            step(0, 0);
        end
        if (m_state == 0) begin
            step(0, 1);
            repeat (4) step(0, 0);
        end
        TARGET = want_hit ? 3'(m_pos) : 3'((m_pos + 1) % N);
        step(0, 1);
        repeat (4) step(0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (LED !== 8'h00) begin n_fail++; $display("FAIL reset_led: got %h want 00", LED); end
        n_checks++; if (HIT !== 1'b0 || MISS !== 1'b0) begin n_fail++; $display("FAIL reset_hitmiss: got %b%b want 00", HIT, MISS); end
        n_checks++; if (SCORE !== 8'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", SCORE); end
        n_checks++; if (STATE !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", STATE); end
        step(1, 0);
        step(1, 0);
        n_checks++; if (STATE !== 2'd0 || LED !== 8'h00) begin n_fail++; $display("FAIL idle_tick: got state %0d led %h want 0 00", STATE, LED); end
    endtask

    task automatic test_hit();
        TARGET = 3'd3;
        step(0, 1);
        repeat (4) step(0, 0);
        n_checks++; if (STATE !== 2'd1 || LED !== 8'h01) begin n_fail++; $display("FAIL start_spin: got state %0d led %h want 1 01", STATE, LED); end
        repeat (3) begin step(1, 0); step(0, 0); end
        n_checks++; if (LED !== 8'h08) begin n_fail++; $display("FAIL spin_pos3: got %h want 08", LED); end
        step(0, 1);
        repeat (4) step(0, 0);
        n_checks++; if (HIT !== 1'b1 || MISS !== 1'b0) begin n_fail++; $display("FAIL hit_flags: got %b%b want 10", HIT, MISS); end
        n_checks++; if (LED !== 8'hFF) begin n_fail++; $display("FAIL hit_led: got %h want ff", LED); end
        n_checks++; if (SCORE !== 8'd1 || STATE !== 2'd2) begin n_fail++; $display("FAIL hit_score: got %0d/%0d want 1/2", SCORE, STATE); end
        repeat (3) begin step(1, 0); step(0, 0); end
        n_checks++; if (HIT !== 1'b1 || STATE !== 2'd2) begin n_fail++; $display("FAIL hold_3ticks: got hit %b state %0d want 1 2", HIT, STATE); end
        step(1, 0);
        n_checks++; if (HIT !== 1'b0 || LED !== 8'h08 || STATE !== 2'd1) begin n_fail++; $display("FAIL show_end: got hit %b led %h state %0d want 0 08 1", HIT, LED, STATE); end
    endtask

    task automatic test_miss();
        TARGET = 3'd5;
        for (int i = 0; i < N && m_pos != 2; i++) step(1, 0);
        n_checks++; if (LED !== 8'h04) begin n_fail++; $display("FAIL miss_pre: got %h want 04", LED); end
        step(0, 1);
        repeat (4) step(0, 0);
        n_checks++; if (MISS !== 1'b1 || HIT !== 1'b0) begin n_fail++; $display("FAIL miss_flags: got hit %b miss %b want 0 1", HIT, MISS); end
        n_checks++; if (LED !== 8'h04 || SCORE !== 8'd1) begin n_fail++; $display("FAIL miss_led_score: got %h/%0d want 04/1", LED, SCORE); end
        step(0, 1);
        repeat (5) step(0, 0);
        n_checks++; if (MISS !== 1'b1 || STATE !== 2'd2 || SCORE !== 8'd1) begin n_fail++; $display("FAIL show_press: got miss %b state %0d score %0d want 1 2 1", MISS, STATE, SCORE); end
        repeat (4) begin step(1, 0); step(0, 0); end
        n_checks++; if (MISS !== 1'b0 || STATE !== 2'd1 || LED !== 8'h04) begin n_fail++; $display("FAIL miss_end: got miss %b state %0d led %h want 0 1 04", MISS, STATE, LED); end
    endtask

    task automatic test_wrap_collision();
        TARGET = 3'd7;
        for (int i = 0; i < N && m_pos != 7; i++) step(1, 0);
        n_checks++; if (LED !== 8'h80) begin n_fail++; $display("FAIL pos7: got %h want 80", LED); end
        step(1, 0);
        n_checks++; if (LED !== 8'h01) begin n_fail++; $display("FAIL wrap: got %h want 01", LED); end
        for (int i = 0; i < N && m_pos != 7; i++) step(1, 0);
        step(0, 1);
        step(0, 0);
        step(0, 0);
        step(1, 0);
        n_checks++; if (HIT !== 1'b1 || LED !== 8'hFF || STATE !== 2'd2) begin n_fail++; $display("FAIL collide: got hit %b led %h state %0d want 1 ff 2", HIT, LED, STATE); end
        n_checks++; if (SCORE !== 8'd2) begin n_fail++; $display("FAIL collide_score: got %0d want 2", SCORE); end
        repeat (4) begin step(1, 0); step(0, 0); end
        n_checks++; if (LED !== 8'h80 || STATE !== 2'd1 || HIT !== 1'b0) begin n_fail++; $display("FAIL collide_resume: got led %h state %0d hit %b want 80 1 0", LED, STATE, HIT); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            do_guess(1);
            n_checks++; if (SCORE !== 8'(i) || HIT !== 1'b1) begin n_fail++; $display("FAIL sat_score8_%0d: got %0d hit %b want %0d 1", i, SCORE, HIT, i); end
            n_checks++; if (SCORE2 !== 2'((i > 3) ? 3 : i)) begin n_fail++; $display("FAIL sat_score2_%0d: got %0d want %0d", i, SCORE2, (i > 3) ? 3 : i); end
        end
    endtask

    task automatic test_held();
        int shows;
        logic [1:0] prev;
        for (int g = 0; g < 20 && m_state != 1; g++) step(1, 0);
        shows = 0;
        prev  = STATE;
        for (int c = 0; c < 100; c++) begin
            step((c % 5) == 4, 1);
            if (STATE == 2'd2 && prev != 2'd2) shows++;
            prev = STATE;
        end
        repeat (3) step(0, 0);
        n_checks++; if (shows !== 1) begin n_fail++; $display("FAIL held_shows: got %0d want 1", shows); end
        n_checks++; if (STATE !== 2'd1 || SCORE !== 8'(m_score)) begin n_fail++; $display("FAIL held_end: got state %0d score %0d want 1 %0d", STATE, SCORE, m_score); end
    endtask

    task automatic test_reset_mid_show();
        for (int g = 0; g < 10 && m_score < 5; g++) do_guess(1);
        if (m_state != 2) do_guess(0);
        n_checks++; if (SCORE !== 8'd5 || STATE !== 2'd2) begin n_fail++; $display("FAIL pre_reset: got score %0d state %0d want 5 2", SCORE, STATE); end
        do_reset();
        n_checks++; if (LED !== 8'h00 || HIT !== 1'b0 || MISS !== 1'b0) begin n_fail++; $display("FAIL midreset_out: got led %h hit %b miss %b want 00 0 0", LED, HIT, MISS); end
        n_checks++; if (SCORE !== 8'd0 || STATE !== 2'd0) begin n_fail++; $display("FAIL midreset_score: got %0d state %0d want 0 0", SCORE, STATE); end
    endtask

    task automatic test_random();
        logic b;
        do_reset();
        b = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) b = ~b;
            if ($urandom_range(0, 60) == 0) TARGET = 3'($urandom_range(0, 7));
            step($urandom_range(0, 3) == 0, b);
            n_checks++; if (LED !== exp_led()) begin n_fail++; $display("FAIL rnd_led@%0d: got %h want %h", c, LED, exp_led()); end
            n_checks++; if (HIT !== m_hit || MISS !== m_miss) begin n_fail++; $display("FAIL rnd_flags@%0d: got %b%b want %b%b", c, HIT, MISS, m_hit, m_miss); end
            n_checks++; if (SCORE !== 8'(m_score) || SCORE2 !== 2'(m_score2)) begin n_fail++; $display("FAIL rnd_score@%0d: got %0d/%0d want %0d/%0d", c, SCORE, SCORE2, m_score, m_score2); end
            n_checks++; if (STATE !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state@%0d: got %0d want %0d", c, STATE, m_state); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; TICK = 1'b0; BTN = 1'b0; TARGET = 3'd0;
        @(negedge CLK);
        test_reset();
        test_hit();
        test_miss();
        test_wrap_collision();
        test_saturation();
        test_held();
        test_reset_mid_show();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
